// File: rtl/lcd_frame_ctrl.sv
// lcd_frame_ctrl
//   Drives a 16x2 HD44780-style character LCD over its 8-bit write-only bus.
//   After reset it waits T_PWR clocks and then sends the init commands 0x38,
//   0x0C, 0x01 and 0x06. It then redraws the full screen: 0x80, characters
//   0..15, 0xC0, characters 16..31. Each character is fetched from a text
//   source through `index`, and the matching `char_in` value is snapshotted
//   CHAR_LAT+1 clocks after `index` changes.
//
//   Optional feature macro: LCD_AUTO_REFRESH_EN
//     defined     - after each frame the controller waits T_CMD clocks in IDLE
//                   and then starts the next frame. refresh_req is ignored.
//     not defined - a frame is redrawn only when a request is pending.
//
//   Ports
//     clk          system clock
//     rst          asynchronous reset, active low
//     refresh_req  1-clk pulse requesting a redraw
//     char_in      character for the current index
//     index        character position being fetched (0..31)
//     lcd_rs       0 = command, 1 = data
//     lcd_rw       always 0
//     lcd_e        enable strobe
//     lcd_data     data bus
//     init_done    high after the init sequence, until reset
//     busy         high while init or a frame is in progress
//
//   Bus timing of one write (cycle 0 is the first clock with new rs/data):
//     E is high on cycles T_SETUP .. T_SETUP+T_EPW-1.
//     The next write's cycle 0 follows T_CMD clocks after E falls, or T_CLR
//     clocks when the command is clear-display (0x01).
//     rs/data are held from cycle 0 until the next write's cycle 0.
//
//   The FSM state is held in state_q, so checkers can bind to it.
module lcd_frame_ctrl #(
    parameter int T_PWR    = 750000,
    parameter int T_SETUP  = 2,
    parameter int T_EPW    = 12,
    parameter int T_CMD    = 2000,
    parameter int T_CLR    = 82000,
    parameter int CHAR_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refresh_req,
    input  logic [7:0] char_in,
    output logic [4:0] index,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       busy
);

    localparam int WR_BASE = T_SETUP + T_EPW;
    localparam int CNT_MAX = (T_PWR > WR_BASE + T_CLR) ? T_PWR : WR_BASE + T_CLR;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] PWR_LAST = CW'(T_PWR - 1);
    localparam logic [CW-1:0] E_RISE   = CW'(T_SETUP);
    localparam logic [CW-1:0] E_FALL   = CW'(WR_BASE);
    localparam logic [CW-1:0] CMD_LAST = CW'(WR_BASE + T_CMD - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(WR_BASE + T_CLR - 1);
    localparam logic [CW-1:0] LAT_LAST = CW'(CHAR_LAT);

    localparam logic [2:0] S_PWR_WAIT = 3'd0;
    localparam logic [2:0] S_INIT     = 3'd1;
    localparam logic [2:0] S_IDLE     = 3'd2;
    localparam logic [2:0] S_ADDR1    = 3'd3;
    localparam logic [2:0] S_CHARS    = 3'd4;
    localparam logic [2:0] S_ADDR2    = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    step_q, step_d;
    logic          fetch_q, fetch_d;
    logic [4:0]    index_q, index_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          e_q, e_d;
    logic          init_done_q, init_done_d;
    logic          busy_q, busy_d;
    logic          wr_last, start_frame, writing_d;
`ifdef LCD_AUTO_REFRESH_EN
    localparam logic [CW-1:0] IDLE_LAST = CW'(T_CMD - 1);
    logic unused_refresh;
    assign unused_refresh = refresh_req;
`else
    logic pending_q, pending_d;
`endif

    // The last cycle of a write's post-E wait. Clear-display needs the long wait.
    assign wr_last = (!rs_q && data_q == 8'h01) ? (cnt_q == CLR_LAT_SEL_CLR()) : (cnt_q == CMD_LAST);

    function automatic logic [CW-1:0] CLR_LAT_SEL_CLR();
        return CLR_LAST;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        fetch_d     = fetch_q;
        index_d     = index_q;
        rs_d        = rs_q;
        data_d      = data_q;
        init_done_d = init_done_q;
        start_frame = 1'b0;
`ifndef LCD_AUTO_REFRESH_EN
        pending_d   = pending_q;
`endif
        case (state_q)
            S_PWR_WAIT: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = S_INIT;
                    step_d  = 2'd0;
                    cnt_d   = '0;
                    rs_d    = 1'b0;
                    data_d  = 8'h38;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_INIT: begin
                if (wr_last) begin
                    cnt_d  = '0;
                    step_d = step_q + 2'd1;
                    case (step_q)
                        2'd0:    data_d = 8'h0C;
                        2'd1:    data_d = 8'h01;
                        2'd2:    data_d = 8'h06;
                        default: begin
                            init_done_d = 1'b1;
                            start_frame = 1'b1;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ADDR1, S_ADDR2: begin
                if (wr_last) begin
                    state_d = S_CHARS;
                    fetch_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHARS: begin
                if (fetch_q) begin
                    // Wait out the text source latency, then snapshot the character.
                    if (cnt_q == LAT_LAST) begin
                        fetch_d = 1'b0;
                        cnt_d   = '0;
                        rs_d    = 1'b1;
                        data_d  = char_in;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (wr_last) begin
                    index_d = index_q + 5'd1;
                    cnt_d   = '0;
                    if (index_q == 5'd15) begin
                        state_d = S_ADDR2;
                        rs_d    = 1'b0;
                        data_d  = 8'hC0;
                    end else if (index_q == 5'd31) begin
                        state_d = S_IDLE;
                    end else begin
                        fetch_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
`ifdef LCD_AUTO_REFRESH_EN
                if (cnt_q == IDLE_LAST) start_frame = 1'b1;
                else                    cnt_d = cnt_q + 1'b1;
`else
                if (pending_q) start_frame = 1'b1;
`endif
            end
            default: begin
                state_d = S_PWR_WAIT;
                cnt_d   = '0;
            end
        endcase

        if (start_frame) begin
            state_d = S_ADDR1;
            cnt_d   = '0;
            rs_d    = 1'b0;
            data_d  = 8'h80;
`ifndef LCD_AUTO_REFRESH_EN
            pending_d = 1'b0;
`endif
        end
`ifndef LCD_AUTO_REFRESH_EN
        // A request in the same clock as the clear still leaves pending set.
        if (refresh_req) pending_d = 1'b1;
`endif

        writing_d = (state_d == S_INIT) || (state_d == S_ADDR1) || (state_d == S_ADDR2) ||
                    (state_d == S_CHARS && !fetch_d);
        e_d       = writing_d && (cnt_d >= E_RISE) && (cnt_d < E_FALL);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_PWR_WAIT;
            cnt_q       <= '0;
            step_q      <= 2'd0;
            fetch_q     <= 1'b0;
            index_q     <= 5'd0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            e_q         <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
`ifndef LCD_AUTO_REFRESH_EN
            pending_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            fetch_q     <= fetch_d;
            index_q     <= index_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            e_q         <= e_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
`ifndef LCD_AUTO_REFRESH_EN
            pending_q   <= pending_d;
`endif
        end
    end

    assign index     = index_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = e_q;
    assign lcd_data  = data_q;
    assign init_done = init_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lcd_frame_ctrl.sv
// tb_lcd_frame_ctrl
//   Self-checking bench for lcd_frame_ctrl with small timing parameters.
//   A scoreboard queue holds the expected {rs,data} of every E pulse.
//   A separate queue holds the expected clocks from E falling to the next
//   bus value, for the init commands.
module tb_lcd_frame_ctrl;
  localparam int T_PWR = 20, T_SETUP = 2, T_EPW = 3, T_CMD = 5, T_CLR = 9, CHAR_LAT = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       refresh_req;
  logic [7:0] char_in;
  logic [4:0] index;
  logic       lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;
  logic       init_done, busy;

  lcd_frame_ctrl #(
    .T_PWR(T_PWR), .T_SETUP(T_SETUP), .T_EPW(T_EPW),
    .T_CMD(T_CMD), .T_CLR(T_CLR), .CHAR_LAT(CHAR_LAT)
  ) dut (
    .clk(clk), .rst(rst), .refresh_req(refresh_req), .char_in(char_in),
    .index(index), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_data(lcd_data), .init_done(init_done), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // text source model: registered, returns 'A'+index; can be corrupted while E is high
  logic [7:0] char_reg = 8'h00;
  logic       toggle_en;
  always @(posedge clk) char_reg <= 8'h41 + {3'b000, index};
  assign char_in = (toggle_en && lcd_e) ? ~char_reg : char_reg;

  // scoreboard
  logic [8:0]  exp_q[$];
  logic [31:0] gap_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int pulse_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
    gap_q.push_back(T_CMD);
    gap_q.push_back(T_CMD);
    gap_q.push_back(T_CLR);
    gap_q.push_back(T_CMD);
  endtask

  task automatic push_frame();
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'(8'h41 + i)});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, 8'(8'h41 + i)});
  endtask

  // bus monitor, sampled on the falling clock edge
  logic       e_prev = 1'b0, gap_run = 1'b0;
  logic [8:0] cur, rise_val = '0, last_val = '0;
  int         gap_cnt = 0, hi_cnt = 0, changes = 0;
  always @(negedge clk) begin
    cur = {lcd_rs, lcd_data};
    if (!rst) begin
      e_prev = 1'b0; gap_run = 1'b0; last_val = '0; changes = 0; hi_cnt = 0;
    end else begin
      if (gap_run) begin
        gap_cnt++;
        if (cur != rise_val) begin
          gap_run = 1'b0;
          if (gap_q.size() > 0) check("gap_after_e_fall", gap_cnt, gap_q.pop_front());
        end
      end
      if (!lcd_e && cur != last_val) changes++;
      if (lcd_e && !e_prev) begin
        pulse_cnt++;
        check("bus_changes_between_pulses", 32'(changes <= 1), 1);
        check("rw_low", lcd_rw, 0);
        check("pulse_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("bus_write", cur, exp_q.pop_front());
        changes  = 0;
        hi_cnt   = 0;
        rise_val = cur;
      end
      if (lcd_e) begin
        hi_cnt++;
        if (e_prev) check("e_high_hold", cur, rise_val);
      end
      if (!lcd_e && e_prev) begin
        check("e_width", hi_cnt, T_EPW);
        check("e_fall_hold", cur, rise_val);
        gap_run = 1'b1;
        gap_cnt = 0;
      end
      e_prev   = lcd_e;
      last_val = cur;
    end
  end

  // driver tasks
  task automatic pulse_refresh();
    @(negedge clk) refresh_req = 1'b1;
    @(negedge clk) refresh_req = 1'b0;
  endtask

  task automatic wait_pwr();
    int n = 0;
    while (lcd_data != 8'h38 && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("pwr_wait_clks", n, T_PWR);
  endtask

  task automatic wait_pulses(input int n);
    int t = 0;
    while (pulse_cnt < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("wait_pulses_in_time", 32'(pulse_cnt >= n), 1);
  endtask

  task automatic wait_idle(input logic need_idle);
    int t = 0;
    while (!(exp_q.size() == 0 && !lcd_e && (!need_idle || !busy)) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_in_time", 32'(t < 3000), 1);
  endtask

  initial begin
    int base;
    rst = 1'b0; refresh_req = 1'b0; toggle_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_index", index, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_e", lcd_e, 0);
    check("rst_data", lcd_data, 0);
    check("rst_init_done", init_done, 0);
    check("rst_busy", busy, 1);

    push_init();
    push_frame();
`ifdef LCD_AUTO_REFRESH_EN
    push_frame();
`endif
    rst = 1'b1;
    wait_pwr();
    wait_pulses(4);
    check("init_done_before_frame", init_done, 0);
    wait_pulses(5);
    check("init_done_at_frame", init_done, 1);
`ifdef LCD_AUTO_REFRESH_EN
    wait_idle(1'b0);
    check("auto_pulse_count", pulse_cnt, 4 + 68);
`else
    wait_idle(1'b1);
    check("frame_end_index", index, 0);
    check("frame_end_busy", busy, 0);
    check("frame_end_init_done", init_done, 1);
    repeat (50) @(negedge clk);
    check("no_frame_without_req", pulse_cnt, 38);

    // one requested frame with char_in corrupted during E, three requests inside it
    toggle_en = 1'b1;
    pulse_refresh();
    push_frame();
    wait_pulses(39);
    push_frame();
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(20, 90)) @(negedge clk);
      pulse_refresh();
    end
    wait_idle(1'b1);
    repeat (200) @(negedge clk);
    check("collapsed_requests", pulse_cnt, 38 + 68);
    check("idle_busy", busy, 0);

    // reset in the middle of an E pulse
    pulse_refresh();
    push_frame();
    base = pulse_cnt;
    wait_pulses(base + 5);
    for (int t = 0; t < 50 && !lcd_e; t++) @(negedge clk);
    check("e_high_before_reset", lcd_e, 1);
    rst = 1'b0;
    #1;
    check("midrst_e", lcd_e, 0);
    check("midrst_data", lcd_data, 0);
    check("midrst_rs", lcd_rs, 0);
    check("midrst_index", index, 0);
    check("midrst_busy", busy, 1);
    check("midrst_init_done", init_done, 0);
    exp_q.delete();
    gap_q.delete();
    push_init();
    push_frame();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_pwr();
    wait_idle(1'b1);
    check("restart_index", index, 0);
    check("restart_init_done", init_done, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
